argmax_frame_decoder: RTL and testbench
=======================================

Name: argmax_frame_decoder

Overview:
- Receive end of the argmax encoder path. The encoder emits (value, index) tuples, one per beat; this block turns a frame of them back into a dense NUM_ELEM-entry vector, with a presence mask and the argmax index of the frame.
- Sits after the encoder stage. Feeds downstream consumers through a valid/ready handshake and holds the frame until it is accepted.

Parameters:
- NUM_ELEM, 4, number of vector slots per frame.
- ELEM_W, 8, width of each element value (unsigned).
- IDX_W, $clog2(NUM_ELEM) (minimum 1), width of the index field.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input tuple valid.
- in_ready  out  1  block can accept a tuple.
- in_value  in  ELEM_W  element value.
- in_index  in  IDX_W  destination slot.
- in_last  in  1  marks the final tuple of a frame.
- out_valid  out  1  reconstructed frame available.
- out_ready  in  1  downstream accepts the frame.
- out_vec  out  NUM_ELEM*ELEM_W  slot k at bits [k*ELEM_W +: ELEM_W].
- out_mask  out  NUM_ELEM  bit k set if slot k was written this frame.
- out_max_index  out  IDX_W  slot holding the largest accepted value.
- err_dup  out  1  at least one duplicate index in this frame.
- err_range  out  1  at least one index >= NUM_ELEM in this frame.

Behaviour:
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0.
  - out_vec, out_mask, out_max_index, err_dup, err_range = 0.
  - Reset during any state (mid-frame or while a frame is pending) discards all frame content.
- Transfers: an input beat transfers when in_valid & in_ready; an output beat transfers when out_valid & out_ready.
- States:
  - IDLE: in_ready = 1. A transfer writes the slot and goes to COLLECT; if in_last is set, it goes straight to EMIT.
  - COLLECT: in_ready = 1. Each transfer writes one slot. A transfer with in_last set goes to EMIT.
  - EMIT: in_ready = 0; out_valid = 1.
    - out_vec, out_mask, out_max_index and the error flags are stable until the output transfer.
    - On the output transfer: all storage, mask, max tracker and error flags clear to 0, and the state returns to IDLE.
    - The next input is accepted no earlier than the cycle after the output transfer.
- Latency: last beat accepted in cycle N gives out_valid = 1 in cycle N+1. With out_ready held at 1, out_valid drops in N+2.
- Slot write, index in range:
  - Slot stores in_value; mask bit set.
  - If the mask bit was already set: err_dup is set (sticky for the frame) and the slot keeps max(old, new).
- Index out of range (in_index >= NUM_ELEM; only possible when NUM_ELEM is not a power of 2):
  - Tuple is discarded and err_range is set (sticky for the frame).
  - in_last on a discarded tuple still ends the frame.
- Max tracking:
  - Updated on every in-range write. Comparison is unsigned.
  - The new index replaces the current one if the new value is greater than or equal to the current max. Ties resolve to the later tuple, matching the encoder's tie rule.
  - If a frame has no in-range writes: out_max_index = 0 and out_mask = 0.
- Empty slots read 0 in out_vec.
- Outputs are registered; no combinational path from in_* to out_*.
- in_valid may stay high during EMIT; the tuple is held off by in_ready = 0 and is not lost.
- Input and output transfers never occur in the same cycle.

Test Plan:
- Single frame, NUM_ELEM=4: tuples (0x10,i0), (0x80,i2), (0x33,i3, last), out_ready=1.
  -> out_valid one cycle after the last beat; out_vec slots = {0x10, 0, 0x80, 0x33}; out_mask = 4'b1101; out_max_index = 2; both error flags 0.
- Backpressure: same frame with out_ready=0 for 5 cycles, then 1.
  -> out_valid and out_vec held stable; in_ready = 0 throughout.
  -> Next frame (0x05,i1,last) gives slot1 = 0x05, out_mask = 4'b0010, other slots 0.
- Duplicate and tie: (0x40,i1), (0x20,i1), (0x40,i3, last).
  -> slot1 = 0x40; err_dup = 1; out_max_index = 3 (tie goes to the later tuple).
- Range error, NUM_ELEM=5, IDX_W=3: (0x7F,i6), (0x01,i0, last).
  -> err_range = 1; out_mask = 5'b00001; out_max_index = 0; slot0 = 0x01.
- Reset mid-frame: two tuples accepted, rst pulsed for 1 cycle, then (0x22,i2,last).
  -> out_mask = 4'b0100, earlier values absent; all outputs were 0 in the cycle after reset.
- Back-to-back single-beat frames, in_valid and out_ready held at 1.
  -> Exactly one frame emitted per 2 cycles; no tuple dropped or duplicated.

Source files
------------

// File: rtl/argmax_frame_decoder.sv
// Rebuilds a dense NUM_ELEM-slot vector from a frame of (value, index) tuples.
// The frame is held with its presence mask, argmax index and error flags until accepted downstream.
module argmax_frame_decoder #(
    parameter int NUM_ELEM = 4,
    parameter int ELEM_W   = 8,
    parameter int IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ELEM_W-1:0]            in_value,
    input  logic [IDX_W-1:0]             in_index,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_ELEM*ELEM_W-1:0]   out_vec,
    output logic [NUM_ELEM-1:0]          out_mask,
    output logic [IDX_W-1:0]             out_max_index,
    output logic                         err_dup,
    output logic                         err_range
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [NUM_ELEM-1:0][ELEM_W-1:0] vec_q, vec_d;
    logic [NUM_ELEM-1:0]             mask_q, mask_d;
    logic [ELEM_W-1:0]               max_val_q, max_val_d;
    logic [IDX_W-1:0]                max_idx_q, max_idx_d;
    logic                            dup_q, dup_d;
    logic                            range_q, range_d;
    logic                            idx_in_range;

    // A power-of-two slot count can never see an out-of-range index.
    generate
        if (NUM_ELEM == (1 << IDX_W)) begin : g_full_range
            assign idx_in_range = 1'b1;
        end else begin : g_partial_range
            localparam logic [IDX_W:0] LIMIT = (IDX_W+1)'(NUM_ELEM);
            assign idx_in_range = ({1'b0, in_index} < LIMIT);
        end
    endgenerate

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            mask_q    <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
            dup_q     <= 1'b0;
            range_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            mask_q    <= mask_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
            dup_q     <= dup_d;
            range_q   <= range_d;
        end
    end

    // Next-state: slot writes, max tracking and frame hand-off.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        mask_d    = mask_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        dup_d     = dup_q;
        range_d   = range_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (in_valid) begin
                    if (idx_in_range) begin
                        for (int k = 0; k < NUM_ELEM; k++) begin
                            if (in_index == IDX_W'(k)) begin
                                if (mask_q[k]) begin
                                    dup_d = 1'b1;
                                    if (in_value > vec_q[k]) begin
                                        vec_d[k] = in_value;
                                    end else begin
                                        vec_d[k] = vec_q[k];
                                    end
                                end else begin
                                    vec_d[k] = in_value;
                                end
                                mask_d[k] = 1'b1;
                            end else begin
                                vec_d[k] = vec_d[k];
                            end
                        end
                        // >= so that ties move to the later tuple.
                        if (in_value >= max_val_q) begin
                            max_val_d = in_value;
                            max_idx_d = in_index;
                        end else begin
                            max_val_d = max_val_q;
                        end
                    end else begin
                        range_d = 1'b1;
                    end
                    state_d = in_last ? EMIT : COLLECT;
                end else begin
                    state_d = state_q;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_d   = IDLE;
                    vec_d     = '0;
                    mask_d    = '0;
                    max_val_d = '0;
                    max_idx_d = '0;
                    dup_d     = 1'b0;
                    range_d   = 1'b0;
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready      = (state_q != EMIT);
    assign out_valid     = (state_q == EMIT);
    assign out_mask      = mask_q;
    assign out_max_index = max_idx_q;
    assign err_dup       = dup_q;
    assign err_range     = range_q;

    generate
        for (genvar g = 0; g < NUM_ELEM; g++) begin : g_flat
            assign out_vec[g*ELEM_W +: ELEM_W] = vec_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_argmax_frame_decoder.sv
// Directed bench for argmax_frame_decoder: a 4-slot instance for the main flows
// and a 5-slot instance for out-of-range indices.
module tb_argmax_frame_decoder;

    logic        clk = 1'b0;
    logic        rst;
    int          n_vec = 0;
    int          n_err = 0;

    logic        in_valid, in_last, out_ready;
    logic [7:0]  in_value;
    logic [1:0]  in_index;
    logic        in_ready, out_valid, err_dup, err_range;
    logic [31:0] out_vec;
    logic [3:0]  out_mask;
    logic [1:0]  out_max_index;

    logic        in_valid5, in_last5, out_ready5;
    logic [7:0]  in_value5;
    logic [2:0]  in_index5;
    logic        in_ready5, out_valid5, err_dup5, err_range5;
    logic [39:0] out_vec5;
    logic [4:0]  out_mask5;
    logic [2:0]  out_max_index5;

    always #5 clk = ~clk;

    argmax_frame_decoder #(.NUM_ELEM(4), .ELEM_W(8)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .in_index(in_index), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .out_mask(out_mask), .out_max_index(out_max_index),
        .err_dup(err_dup), .err_range(err_range)
    );

    argmax_frame_decoder #(.NUM_ELEM(5), .ELEM_W(8)) u_dut5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_value(in_value5),
        .in_index(in_index5), .in_last(in_last5),
        .out_valid(out_valid5), .out_ready(out_ready5), .out_vec(out_vec5),
        .out_mask(out_mask5), .out_max_index(out_max_index5),
        .err_dup(err_dup5), .err_range(err_range5)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] v, input logic [1:0] i, input logic last);
        check_eq("in_ready_before_beat", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_value = v; in_index = i; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic beat5(input logic [7:0] v, input logic [2:0] i, input logic last);
        in_valid5 = 1'b1; in_value5 = v; in_index5 = i; in_last5 = last;
        @(posedge clk); #1;
        in_valid5 = 1'b0; in_last5 = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [31:0] vec, input logic [3:0] mask,
                               input logic [1:0] mx, input logic dup, input logic rng);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_vec"},   64'(out_vec), 64'(vec));
        check_eq({tag, "_mask"},  64'(out_mask), 64'(mask));
        check_eq({tag, "_max"},   64'(out_max_index), 64'(mx));
        check_eq({tag, "_dup"},   64'(err_dup), 64'(dup));
        check_eq({tag, "_range"}, 64'(err_range), 64'(rng));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_value = '0; in_index = '0; out_ready = 1'b0;
        in_valid5 = 1'b0; in_last5 = 1'b0; in_value5 = '0; in_index5 = '0; out_ready5 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready",  64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_vec",       64'(out_vec), 64'd0);
        check_eq("rst_mask",      64'(out_mask), 64'd0);
        check_eq("rst_max",       64'(out_max_index), 64'd0);
        check_eq("rst_errs",      64'({err_dup, err_range}), 64'd0);
        rst = 1'b0;

        // Single frame with immediate acceptance
        out_ready = 1'b1;
        beat(8'h10, 2'd0, 1'b0);
        check_eq("t1_no_early_valid", 64'(out_valid), 64'd0);
        beat(8'h80, 2'd2, 1'b0);
        beat(8'h33, 2'd3, 1'b1);
        check_frame("t1", 32'h3380_0010, 4'b1101, 2'd2, 1'b0, 1'b0);
        check_eq("t1_in_ready_emit", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check_eq("t1_valid_drop", 64'(out_valid), 64'd0);
        check_eq("t1_mask_clear", 64'(out_mask), 64'd0);
        check_eq("t1_vec_clear",  64'(out_vec), 64'd0);

        // Backpressure, with the next tuple waiting on in_valid
        out_ready = 1'b0;
        beat(8'h10, 2'd0, 1'b0);
        beat(8'h80, 2'd2, 1'b0);
        beat(8'h33, 2'd3, 1'b1);
        in_valid = 1'b1; in_value = 8'h05; in_index = 2'd1; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check_frame("t2_hold", 32'h3380_0010, 4'b1101, 2'd2, 1'b0, 1'b0);
            check_eq("t2_in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("t2_released", 64'(out_valid), 64'd0);
        check_eq("t2_in_ready_back", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        check_frame("t2_next", 32'h0000_0500, 4'b0010, 2'd1, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Duplicate index and max tie
        beat(8'h40, 2'd1, 1'b0);
        beat(8'h20, 2'd1, 1'b0);
        beat(8'h40, 2'd3, 1'b1);
        check_frame("t3", 32'h4000_4000, 4'b1010, 2'd3, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_eq("t3_dup_clear", 64'(err_dup), 64'd0);

        // Reset mid-frame
        beat(8'h11, 2'd0, 1'b0);
        beat(8'h44, 2'd3, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("t4_rst_valid", 64'(out_valid), 64'd0);
        check_eq("t4_rst_vec",   64'(out_vec), 64'd0);
        check_eq("t4_rst_mask",  64'(out_mask), 64'd0);
        check_eq("t4_rst_max",   64'(out_max_index), 64'd0);
        beat(8'h22, 2'd2, 1'b1);
        check_frame("t4", 32'h0022_0000, 4'b0100, 2'd2, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Back-to-back single-beat frames
        in_valid = 1'b1; in_last = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_value = 8'(8'h60 + j);
            in_index = 2'(j);
            @(posedge clk); #1;
            check_eq("t5_valid_on",  64'(out_valid), 64'd1);
            check_eq("t5_vec",       64'(out_vec), 64'(32'(8'h60 + j) << (8 * j)));
            check_eq("t5_mask",      64'(out_mask), 64'(4'b0001 << j));
            check_eq("t5_max",       64'(out_max_index), 64'(j));
            @(posedge clk); #1;
            check_eq("t5_valid_off", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b0; in_last = 1'b0;

        // Out-of-range indices on the 5-slot instance
        out_ready5 = 1'b1;
        beat5(8'h7F, 3'd6, 1'b0);
        beat5(8'h01, 3'd0, 1'b1);
        check_eq("t6_valid", 64'(out_valid5), 64'd1);
        check_eq("t6_range", 64'(err_range5), 64'd1);
        check_eq("t6_dup",   64'(err_dup5), 64'd0);
        check_eq("t6_mask",  64'(out_mask5), 64'h01);
        check_eq("t6_max",   64'(out_max_index5), 64'd0);
        check_eq("t6_vec",   64'(out_vec5), 64'h01);
        @(posedge clk); #1;
        check_eq("t6_range_clear", 64'(err_range5), 64'd0);
        beat5(8'h55, 3'd7, 1'b1);
        check_eq("t7_valid", 64'(out_valid5), 64'd1);
        check_eq("t7_range", 64'(err_range5), 64'd1);
        check_eq("t7_mask",  64'(out_mask5), 64'd0);
        check_eq("t7_max",   64'(out_max_index5), 64'd0);
        check_eq("t7_vec",   64'(out_vec5), 64'd0);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
